// File: rtl/audio_sd_dac.sv
// audio_sd_dac: sample FIFO feeding a first-order sigma-delta modulator that
// produces a 1-bit pulse-density bitstream for an RC-filtered audio pin.
module audio_sd_dac #(
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RATE_DIV   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    input  logic                          underflow_clr,
    output logic                          pdm_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(RATE_DIV);

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    rate_cnt;
    logic [SAMPLE_W-1:0] cur;
    logic [SAMPLE_W-1:0] acc;

    logic                push_c;
    logic                wrap_c;
    logic                pop_c;
    logic                empty_pop_c;
    logic [LVL_W-1:0]    level_nxt_c;
    logic [SAMPLE_W:0]   sum_c;

    // Handshake, pop timing, next level and modulator sum.
    always_comb begin
        push_c      = 1'b0;
        wrap_c      = 1'b0;
        pop_c       = 1'b0;
        empty_pop_c = 1'b0;
        level_nxt_c = fifo_level;
        sum_c       = '0;

        push_c      = sample_valid && sample_ready;
        wrap_c      = enable && (rate_cnt == CNT_W'(RATE_DIV - 1));
        pop_c       = wrap_c && (fifo_level != '0);
        empty_pop_c = wrap_c && (fifo_level == '0);
        level_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
        sum_c       = {1'b0, acc} + {1'b0, cur};
    end

    // Sample storage; contents need no reset since the level gates reads.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers, level, ready flag and current sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            sample_ready <= 1'b1;
            cur          <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                cur    <= mem[rd_ptr];
            end
            fifo_level   <= level_nxt_c;
            sample_ready <= (level_nxt_c != LVL_W'(FIFO_DEPTH));
        end
    end

    // Consumption rate counter; held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_cnt <= '0;
        end else if (!enable || wrap_c) begin
            rate_cnt <= '0;
        end else begin
            rate_cnt <= rate_cnt + CNT_W'(1);
        end
    end

    // Sticky starvation flag; a new empty pop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (empty_pop_c) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

    // First-order sigma-delta: the accumulator carry is the output bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pdm_out <= 1'b0;
        end else if (!enable) begin
            acc     <= '0;
            pdm_out <= 1'b0;
        end else begin
            acc     <= sum_c[SAMPLE_W-1:0];
            pdm_out <= sum_c[SAMPLE_W];
        end
    end

endmodule

// File: tb/tb_audio_sd_dac.sv
// Directed bench for audio_sd_dac with default parameters (8-bit, depth 4, /64).
module tb_audio_sd_dac;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic [2:0] fifo_level;
    logic       underflow;
    logic       underflow_clr;
    logic       pdm_out;

    int errors = 0;
    int checks = 0;

    audio_sd_dac #(
        .SAMPLE_W   (8),
        .FIFO_DEPTH (4),
        .RATE_DIV   (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .pdm_out       (pdm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles and count pdm_out ones observed after each edge.
    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pdm_out) ones++;
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        enable        = 1'b0;
        sample_valid  = 1'b0;
        sample_in     = 8'h00;
        underflow_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    logic [7:0] dens_val [3];
    int         dens_exp [3];
    logic [7:0] seq_val  [4];
    int         ones;
    int         acc_ones;

    initial begin
        dens_val[0] = 8'h80; dens_exp[0] = 128;
        dens_val[1] = 8'hFF; dens_exp[1] = 255;
        dens_val[2] = 8'h00; dens_exp[2] = 0;
        seq_val[0]  = 8'h40; seq_val[1] = 8'h80; seq_val[2] = 8'hC0; seq_val[3] = 8'h20;

        // 1: idle after reset
        do_reset();
        for (int i = 0; i < 200; i++) begin
            tick();
            check_eq("idle_pdm", 32'(pdm_out), 32'd0);
            check_eq("idle_ready", 32'(sample_ready), 32'd1);
            check_eq("idle_level", 32'(fifo_level), 32'd0);
            check_eq("idle_underflow", 32'(underflow), 32'd0);
        end

        // 2: ones density over 256 cycles equals the sample value
        for (int k = 0; k < 3; k++) begin
            do_reset();
            push(dens_val[k]);
            check_eq("dens_level_pushed", 32'(fifo_level), 32'd1);
            enable = 1'b1;
            count_ones(63, ones);
            check_eq("dens_level_prewrap", 32'(fifo_level), 32'd1);
            tick();
            check_eq("dens_level_popped", 32'(fifo_level), 32'd0);
            count_ones(256, ones);
            check_eq("dens_ones", 32'(ones), 32'(dens_exp[k]));
            check_eq("dens_underflow", 32'(underflow), 32'd1);
        end

        // 3: fill to full, overflow attempt, ordered pops
        do_reset();
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_in = seq_val[i];
            tick();
        end
        check_eq("full_level", 32'(fifo_level), 32'd4);
        check_eq("full_ready", 32'(sample_ready), 32'd0);
        sample_in = 8'hFC;
        tick();
        sample_valid = 1'b0;
        check_eq("full_level_after_extra", 32'(fifo_level), 32'd4);
        enable = 1'b1;
        count_ones(63, ones);
        check_eq("pop0_prewrap_level", 32'(fifo_level), 32'd4);
        tick();
        check_eq("pop0_level", 32'(fifo_level), 32'd3);
        check_eq("pop0_ready", 32'(sample_ready), 32'd1);
        count_ones(64, ones);
        check_eq("seq_ones_s0", 32'(ones), 32'd16);
        check_eq("pop1_level", 32'(fifo_level), 32'd2);
        count_ones(64, ones);
        check_eq("seq_ones_s1", 32'(ones), 32'd32);
        check_eq("pop2_level", 32'(fifo_level), 32'd1);
        count_ones(64, ones);
        check_eq("seq_ones_s2", 32'(ones), 32'd48);
        check_eq("pop3_level", 32'(fifo_level), 32'd0);

        // 4: underflow on empty pop, cur held, clear behaviour
        count_ones(63, acc_ones);
        check_eq("uf_before_wrap", 32'(underflow), 32'd0);
        tick();
        if (pdm_out) acc_ones++;
        check_eq("seq_ones_s3", 32'(acc_ones), 32'd8);
        check_eq("uf_set", 32'(underflow), 32'd1);
        check_eq("uf_level", 32'(fifo_level), 32'd0);
        count_ones(63, acc_ones);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        if (pdm_out) acc_ones++;
        check_eq("uf_cur_held_ones", 32'(acc_ones), 32'd8);
        check_eq("uf_set_beats_clr", 32'(underflow), 32'd1);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check_eq("uf_cleared", 32'(underflow), 32'd0);

        // 5: drop enable mid-stream
        do_reset();
        push(8'h80);
        push(8'h40);
        enable = 1'b1;
        count_ones(64, ones);
        check_eq("pause_level_start", 32'(fifo_level), 32'd1);
        count_ones(20, ones);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("pause_pdm", 32'(pdm_out), 32'd0);
            check_eq("pause_level", 32'(fifo_level), 32'd1);
        end
        enable = 1'b1;
        count_ones(63, acc_ones);
        check_eq("resume_level_prewrap", 32'(fifo_level), 32'd1);
        tick();
        if (pdm_out) acc_ones++;
        check_eq("resume_level_pop", 32'(fifo_level), 32'd0);
        check_eq("resume_cur_ones", 32'(acc_ones), 32'd32);
        check_eq("resume_underflow", 32'(underflow), 32'd0);

        // 6: async reset between clock edges
        do_reset();
        for (int i = 0; i < 4; i++) push(8'hFF);
        enable = 1'b1;
        count_ones(64, ones);
        tick();
        tick();
        check_eq("arst_pre_pdm", 32'(pdm_out), 32'd1);
        check_eq("arst_pre_level", 32'(fifo_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_pdm", 32'(pdm_out), 32'd0);
        check_eq("arst_level", 32'(fifo_level), 32'd0);
        check_eq("arst_ready", 32'(sample_ready), 32'd1);
        check_eq("arst_underflow", 32'(underflow), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b0;
        tick();
        check_eq("arst_after_level", 32'(fifo_level), 32'd0);
        check_eq("arst_after_ready", 32'(sample_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_sd_dac.md
Name: audio_sd_dac

Overview:
- Output stage directly downstream of the mixer: takes the mixed audio sample stream and turns it into a 1-bit pulse-density (first-order sigma-delta) bitstream that drives the board's RC-filtered audio pin.
- A small sample FIFO decouples the mixer's sample strobe from the DAC's fixed consumption rate.
- A sticky underflow flag reports starvation to the sequencing logic.

Parameters:
- SAMPLE_W, 8, width of the unsigned input sample; 0 is silence floor, 2^SAMPLE_W-1 is full scale.
- FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- RATE_DIV, 64, clk cycles per consumed sample; must be at least 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = run rate counter and modulator; 0 = idle, bitstream forced low.
- sample_in  input  SAMPLE_W  mixed sample from the mixer.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  FIFO can accept; a push occurs when sample_valid && sample_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of stored entries.
- underflow  output  1  sticky: a pop was due while the FIFO was empty.
- underflow_clr  input  1  clears underflow.
- pdm_out  output  1  registered sigma-delta bitstream.

Behaviour:
- Reset (async, rst_n=0) clears the following, all of which stay cleared while rst_n is low:
  - FIFO pointers; fifo_level=0.
  - rate counter; current sample cur=0; accumulator acc=0.
  - pdm_out=0, underflow=0.
  - sample_ready=1 (registered, derived from !full).
- FIFO push:
  - sample_ready = (fifo_level != FIFO_DEPTH), computed from registered level only.
  - A pop in the same cycle does not make room for a push that cycle.
  - Pushes are accepted regardless of enable.
- Rate counter: while enable=1 it counts 0..RATE_DIV-1 and wraps. The wrap cycle is count==RATE_DIV-1.
- Pop on the wrap cycle:
  - If fifo_level>0: head goes to cur, the read pointer advances, and the level decrements.
  - If fifo_level==0: cur holds its last value and underflow is set. A push in that same cycle is stored but not popped.
  - Push and pop in the same cycle with 0<level<FIFO_DEPTH: the level is unchanged.
- Latency: a sample pushed into an empty FIFO is loaded into cur at the next wrap. From the cycle after the load, the modulator uses the new cur.
- Modulator, each cycle with enable=1:
  - {carry, acc} <= acc + cur, computed SAMPLE_W+1 bits wide; acc keeps the low SAMPLE_W bits and wraps.
  - pdm_out <= carry.
  - Ones density over 2^SAMPLE_W cycles equals cur / 2^SAMPLE_W exactly.
- enable=0:
  - Rate counter is held at 0, acc is cleared, and pdm_out <= 0 on the next edge.
  - cur and the FIFO contents are retained.
  - On re-enable, counting restarts from 0 and the first wrap occurs RATE_DIV cycles after the first enabled cycle.
- underflow:
  - Set on an empty-pop event; cleared by underflow_clr.
  - If both occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. Level never exceeds FIFO_DEPTH and never goes below 0.
- Async reset asserted mid-operation: every register returns to its reset value immediately, with no clk edge required. Operation resumes from the empty state after release.

Test Plan:
1. Reset then release with enable=0, no pushes:
   - Required: pdm_out=0, sample_ready=1, fifo_level=0, underflow=0, held for 200 cycles.
2. Push 0x80 once, then enable=1; count pdm_out ones over the 256 cycles after cur loads:
   - Required: exactly 128 ones.
   - Repeat with 0xFF: required 255 ones. Repeat with 0x00: required 0 ones.
3. With enable=0, push 4 samples:
   - Required: fifo_level=4 and sample_ready=0.
   - A 5th valid cycle is not stored, and a later pop still yields the 1st sample.
   - Samples pop in push order at counts 63, 127, 191, 255 after enable.
4. enable=1 with the FIFO empty:
   - Required: underflow rises on the wrap cycle (count 63) and cur is unchanged.
   - underflow_clr in the same cycle as a second empty-pop leaves underflow=1.
   - underflow_clr alone clears it.
5. Mid-stream, drop enable for 10 cycles:
   - Required: pdm_out=0 one cycle later; fifo_level and cur unchanged.
   - After re-enable, the next pop occurs exactly 64 cycles later.
6. Pulse rst_n low between clock edges while fifo_level=3 and pdm_out=1:
   - Required: pdm_out=0, fifo_level=0 and sample_ready=1 before the next posedge.
